// File: rtl/mcu_spi_pkg.sv
// Shared types and constants for the MCU SPI control-link front end.
package mcu_spi_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT
  } frame_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous SPI pin, with rise/fall
// detection against one further registered copy of the synced level.
module spi_sync_edge
  import mcu_spi_pkg::*;
#(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/mcu_spi_slave.sv
// MCU control-link SPI mode-0 slave: source select (BL616 / M0S Dock),
// clk32-domain byte deserialiser, MISO reply serialiser and interrupt line.
module mcu_spi_slave
  import mcu_spi_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int EXT_DEBOUNCE = 2
) (
  input  logic              clk32,
  input  logic              reset_n,
  input  logic              int_sclk,
  input  logic              int_csn,
  input  logic              int_mosi,
  input  logic              ext_sclk,
  input  logic              ext_csn,
  input  logic              ext_mosi,
  output logic              miso,
  output logic              intn,
  output logic              ext_active,
  output logic              rx_strobe,
  output logic [BYTE_W-1:0] rx_data,
  output logic              rx_start,
  output logic              frame_active,
  input  logic [BYTE_W-1:0] tx_data,
  output logic              tx_load,
  input  logic              irq_set,
  input  logic              irq_clr
);

  localparam int                DEB_W    = $clog2(EXT_DEBOUNCE + 1);
  localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(EXT_DEBOUNCE - 1);
  localparam int                CNT_W    = $clog2(BYTE_W);
  localparam logic [CNT_W-1:0]  BIT_LAST = CNT_W'(BYTE_W - 1);

  logic int_sclk_lvl, int_sclk_rise, int_sclk_fall;
  logic int_csn_lvl, int_csn_rise, int_csn_fall;
  logic ext_sclk_lvl, ext_sclk_rise, ext_sclk_fall;
  logic ext_csn_lvl, ext_csn_rise, ext_csn_fall;
  logic unused_sync_bits;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_int_sclk (
    .clk(clk32), .rst_n(reset_n), .din(int_sclk),
    .level(int_sclk_lvl), .rise(int_sclk_rise), .fall(int_sclk_fall));
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_int_csn (
    .clk(clk32), .rst_n(reset_n), .din(int_csn),
    .level(int_csn_lvl), .rise(int_csn_rise), .fall(int_csn_fall));
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_ext_sclk (
    .clk(clk32), .rst_n(reset_n), .din(ext_sclk),
    .level(ext_sclk_lvl), .rise(ext_sclk_rise), .fall(ext_sclk_fall));
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ext_csn (
    .clk(clk32), .rst_n(reset_n), .din(ext_csn),
    .level(ext_csn_lvl), .rise(ext_csn_rise), .fall(ext_csn_fall));

  // Frames end on the csn level, so csn rise and sclk level are not needed.
  assign unused_sync_bits = ^{int_sclk_lvl, ext_sclk_lvl, int_csn_rise, ext_csn_rise};

  logic [SYNC_STAGES-1:0] int_mosi_q, int_mosi_d, ext_mosi_q, ext_mosi_d;
  logic [DEB_W-1:0]       deb_cnt_q, deb_cnt_d;
  logic                   ext_active_q, ext_active_d;
  logic                   intn_q, intn_d;
  frame_state_e           state_q, state_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0]      tx_shift_q, tx_shift_d;
  logic [BYTE_W-1:0]      rx_shift_q, rx_shift_d;
  logic [BYTE_W-1:0]      rx_data_q, rx_data_d;
  logic                   rx_strobe_q, rx_strobe_d;
  logic                   rx_start_q, rx_start_d;
  logic                   first_q, first_d;
  logic                   miso_q, miso_d;

  logic sel_csn, sel_csn_fall, sel_sclk_rise, sel_sclk_fall, sel_mosi, switching;

  always_comb begin
    int_mosi_d = {int_mosi_q[SYNC_STAGES-2:0], int_mosi};
    ext_mosi_d = {ext_mosi_q[SYNC_STAGES-2:0], ext_mosi};
  end

  assign sel_csn       = ext_active_q ? ext_csn_lvl   : int_csn_lvl;
  assign sel_csn_fall  = ext_active_q ? ext_csn_fall  : int_csn_fall;
  assign sel_sclk_rise = ext_active_q ? ext_sclk_rise : int_sclk_rise;
  assign sel_sclk_fall = ext_active_q ? ext_sclk_fall : int_sclk_fall;
  assign sel_mosi      = ext_active_q ? ext_mosi_q[SYNC_STAGES-1] : int_mosi_q[SYNC_STAGES-1];

  // Debounce counter saturates; the external source, once chosen, stays chosen.
  always_comb begin
    deb_cnt_d    = deb_cnt_q;
    ext_active_d = ext_active_q;
    if (ext_csn_lvl) begin
      deb_cnt_d = '0;
    end else begin
      if (deb_cnt_q != DEB_LAST) deb_cnt_d = deb_cnt_q + DEB_W'(1);
      if (deb_cnt_q == DEB_LAST) ext_active_d = 1'b1;
    end
  end

  assign switching = ext_active_d & ~ext_active_q;
  assign intn_d    = ~((~intn_q & ~irq_clr) | irq_set);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    tx_shift_d  = tx_shift_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    rx_strobe_d = 1'b0;
    rx_start_d  = 1'b0;
    first_d     = first_q;
    miso_d      = miso_q;
    case (state_q)
      IDLE: begin
        if (sel_csn_fall) begin
          state_d = LOAD;
          first_d = 1'b1;
        end
      end
      LOAD: begin
        tx_shift_d = tx_data;
        miso_d     = tx_data[BYTE_W-1];
        bit_cnt_d  = '0;
        state_d    = SHIFT;
      end
      SHIFT: begin
        if (sel_sclk_rise) begin
          rx_shift_d = {rx_shift_q[BYTE_W-2:0], sel_mosi};
          bit_cnt_d  = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == BIT_LAST) begin
            rx_strobe_d = 1'b1;
            rx_data_d   = {rx_shift_q[BYTE_W-2:0], sel_mosi};
            rx_start_d  = first_q;
            first_d     = 1'b0;
          end
        // A zero count means the current byte has not shifted any bit yet,
        // so the trailing fall of the previous byte is not a data edge.
        end else if (sel_sclk_fall && bit_cnt_q != '0) begin
          miso_d     = tx_shift_q[BYTE_W-2];
          tx_shift_d = {tx_shift_q[BYTE_W-2:0], 1'b0};
        end
        if (rx_strobe_q) state_d = LOAD;
      end
      default: state_d = IDLE;
    endcase
    if (sel_csn || switching) state_d = IDLE;
  end

  always_ff @(posedge clk32 or negedge reset_n) begin
    if (!reset_n) begin
      int_mosi_q   <= '0;
      ext_mosi_q   <= '0;
      deb_cnt_q    <= '0;
      ext_active_q <= 1'b0;
      intn_q       <= 1'b1;
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      tx_shift_q   <= '0;
      rx_shift_q   <= '0;
      rx_data_q    <= '0;
      rx_strobe_q  <= 1'b0;
      rx_start_q   <= 1'b0;
      first_q      <= 1'b0;
      miso_q       <= 1'b0;
    end else begin
      int_mosi_q   <= int_mosi_d;
      ext_mosi_q   <= ext_mosi_d;
      deb_cnt_q    <= deb_cnt_d;
      ext_active_q <= ext_active_d;
      intn_q       <= intn_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      tx_shift_q   <= tx_shift_d;
      rx_shift_q   <= rx_shift_d;
      rx_data_q    <= rx_data_d;
      rx_strobe_q  <= rx_strobe_d;
      rx_start_q   <= rx_start_d;
      first_q      <= first_d;
      miso_q       <= miso_d;
    end
  end

  assign miso         = miso_q;
  assign intn         = intn_q;
  assign ext_active   = ext_active_q;
  assign rx_strobe    = rx_strobe_q;
  assign rx_data      = rx_data_q;
  assign rx_start     = rx_start_q;
  assign frame_active = ~sel_csn;
  assign tx_load      = (state_q == LOAD);

endmodule

// File: tb/tb_mcu_spi_slave.sv
// Directed bench for mcu_spi_slave: SPI master model on both pin sets,
// strobe/load monitor and hand-computed expected bytes.
module tb_mcu_spi_slave;

  logic       clk32;
  logic       reset_n;
  logic       int_sclk, int_csn, int_mosi;
  logic       ext_sclk, ext_csn, ext_mosi;
  logic       miso, intn, ext_active;
  logic       rx_strobe, rx_start, frame_active, tx_load;
  logic [7:0] rx_data, tx_data;
  logic       irq_set, irq_clr;

  int         compareCount = 0;
  int         failCount = 0;
  int         strobeCount = 0;
  int         loadCount = 0;
  logic [7:0] rxLog[$];
  logic       startLog[$];
  logic [7:0] misoByte;
  int         baseStrobes;

  mcu_spi_slave #(.SYNC_STAGES(2), .EXT_DEBOUNCE(2)) dut (
    .clk32(clk32), .reset_n(reset_n),
    .int_sclk(int_sclk), .int_csn(int_csn), .int_mosi(int_mosi),
    .ext_sclk(ext_sclk), .ext_csn(ext_csn), .ext_mosi(ext_mosi),
    .miso(miso), .intn(intn), .ext_active(ext_active),
    .rx_strobe(rx_strobe), .rx_data(rx_data), .rx_start(rx_start),
    .frame_active(frame_active), .tx_data(tx_data), .tx_load(tx_load),
    .irq_set(irq_set), .irq_clr(irq_clr));

  initial clk32 = 1'b0;
  always #16 clk32 = ~clk32;

  // Record every received byte and every tx_load pulse, sampled mid-cycle.
  always @(negedge clk32) begin
    if (rx_strobe) begin
      strobeCount++;
      rxLog.push_back(rx_data);
      startLog.push_back(rx_start);
    end
    if (tx_load) loadCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [7:0] dataAt(input int idx);
    return (idx < rxLog.size()) ? rxLog[idx] : 8'hxx;
  endfunction

  function automatic logic startAt(input int idx);
    return (idx < startLog.size()) ? startLog[idx] : 1'bx;
  endfunction

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk32);
  endtask

  task automatic setPins(input bit useExt, input logic sclkV, input logic csnV, input logic mosiV);
    if (useExt) begin
      ext_sclk = sclkV; ext_csn = csnV; ext_mosi = mosiV;
    end else begin
      int_sclk = sclkV; int_csn = csnV; int_mosi = mosiV;
    end
  endtask

  // Mode-0 master at clk32/16: MISO is sampled just before each rising edge.
  // endFrame raises csn one cycle after the last rising edge.
  task automatic applyStimulus(input bit useExt, input logic [7:0] mosiByte, input int nBits,
                               input bit endFrame, output logic [7:0] misoOut);
    logic [7:0] bits;
    bits = mosiByte;
    misoOut = 8'h00;
    for (int i = 0; i < nBits; i++) begin
      setPins(useExt, 1'b0, 1'b0, bits[7-i]);
      waitCycles(8);
      misoOut[7-i] = miso;
      setPins(useExt, 1'b1, 1'b0, bits[7-i]);
      if (endFrame && i == nBits - 1) begin
        waitCycles(1);
        setPins(useExt, 1'b1, 1'b1, bits[7-i]);
        waitCycles(7);
        setPins(useExt, 1'b0, 1'b1, 1'b0);
        waitCycles(8);
      end else begin
        waitCycles(8);
      end
    end
  endtask

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    int_sclk = 1'b0; int_csn = 1'b1; int_mosi = 1'b0;
    ext_sclk = 1'b0; ext_csn = 1'b1; ext_mosi = 1'b0;
    tx_data = 8'h81; irq_set = 1'b0; irq_clr = 1'b0;
    waitCycles(3);
    checkOutput("reset miso", miso, 1'b0);
    checkOutput("reset intn", intn, 1'b1);
    checkOutput("reset ext_active", ext_active, 1'b0);
    checkOutput("reset rx_strobe", rx_strobe, 1'b0);
    checkOutput("reset rx_data", rx_data, 8'h00);
    checkOutput("reset rx_start", rx_start, 1'b0);
    checkOutput("reset frame_active", frame_active, 1'b0);
    checkOutput("reset tx_load", tx_load, 1'b0);
    reset_n = 1'b1;
    waitCycles(5);

    $display("[TB] two-byte internal frame");
    applyStimulus(1'b0, 8'hA5, 8, 1'b0, misoByte);
    checkOutput("frame_active in frame", frame_active, 1'b1);
    checkOutput("miso byte0", misoByte, 8'h81);
    applyStimulus(1'b0, 8'h3C, 8, 1'b1, misoByte);
    checkOutput("miso byte1", misoByte, 8'h81);
    waitCycles(4);
    checkOutput("strobe count", strobeCount, 2);
    checkOutput("rx byte0", dataAt(0), 8'hA5);
    checkOutput("rx_start byte0", startAt(0), 1'b1);
    checkOutput("rx byte1", dataAt(1), 8'h3C);
    checkOutput("rx_start byte1", startAt(1), 1'b0);
    checkOutput("tx_load count", loadCount, 2);
    checkOutput("frame_active after", frame_active, 1'b0);

    $display("[TB] aborted partial byte");
    applyStimulus(1'b0, 8'hFF, 5, 1'b0, misoByte);
    setPins(1'b0, 1'b1, 1'b1, 1'b1);
    waitCycles(8);
    setPins(1'b0, 1'b0, 1'b1, 1'b0);
    waitCycles(8);
    checkOutput("abort no strobe", strobeCount, 2);
    checkOutput("abort rx_data held", rx_data, 8'h3C);
    applyStimulus(1'b0, 8'h12, 8, 1'b1, misoByte);
    waitCycles(4);
    checkOutput("post-abort rx", dataAt(2), 8'h12);
    checkOutput("post-abort rx_start", startAt(2), 1'b1);

    $display("[TB] source switch");
    setPins(1'b1, 1'b0, 1'b0, 1'b0);
    waitCycles(1);
    setPins(1'b1, 1'b0, 1'b1, 1'b0);
    waitCycles(6);
    checkOutput("ext glitch ignored", ext_active, 1'b0);
    setPins(1'b1, 1'b0, 1'b0, 1'b0);
    waitCycles(4);
    setPins(1'b1, 1'b0, 1'b1, 1'b0);
    waitCycles(6);
    checkOutput("ext selected", ext_active, 1'b1);
    baseStrobes = strobeCount;
    applyStimulus(1'b0, 8'hF0, 8, 1'b1, misoByte);
    waitCycles(4);
    checkOutput("int ignored", strobeCount, baseStrobes);
    tx_data = 8'h6E;
    applyStimulus(1'b1, 8'h5A, 8, 1'b1, misoByte);
    waitCycles(4);
    checkOutput("ext strobe count", strobeCount, baseStrobes + 1);
    checkOutput("ext rx_data", rx_data, 8'h5A);
    checkOutput("ext rx_start", startAt(baseStrobes), 1'b1);
    checkOutput("ext miso byte", misoByte, 8'h6E);

    $display("[TB] interrupt line");
    irq_set = 1'b1;
    waitCycles(1);
    irq_set = 1'b0;
    checkOutput("irq set", intn, 1'b0);
    irq_clr = 1'b1;
    waitCycles(1);
    irq_clr = 1'b0;
    checkOutput("irq clr", intn, 1'b1);
    irq_set = 1'b1; irq_clr = 1'b1;
    waitCycles(1);
    irq_set = 1'b0; irq_clr = 1'b0;
    checkOutput("irq set wins", intn, 1'b0);

    $display("[TB] reset mid-frame");
    applyStimulus(1'b1, 8'hC3, 3, 1'b0, misoByte);
    checkOutput("pre-reset miso", miso, 1'b1);
    reset_n = 1'b0;
    setPins(1'b1, 1'b0, 1'b1, 1'b0);
    #1;
    checkOutput("mid reset miso", miso, 1'b0);
    checkOutput("mid reset intn", intn, 1'b1);
    checkOutput("mid reset ext_active", ext_active, 1'b0);
    checkOutput("mid reset rx_data", rx_data, 8'h00);
    checkOutput("mid reset frame_active", frame_active, 1'b0);
    checkOutput("mid reset tx_load", tx_load, 1'b0);
    waitCycles(3);
    reset_n = 1'b1;
    waitCycles(6);
    checkOutput("post reset ext_active", ext_active, 1'b0);
    baseStrobes = strobeCount;
    applyStimulus(1'b0, 8'hC3, 8, 1'b1, misoByte);
    waitCycles(4);
    checkOutput("post reset strobes", strobeCount, baseStrobes + 1);
    checkOutput("post reset rx_data", rx_data, 8'hC3);
    checkOutput("post reset rx_start", startAt(baseStrobes), 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
